bubble_page_streamer: RTL and testbench

//  Parametrised successor to the fixed two-output page buffer between SPILoader and the bubble outputs.

---
 rtl/bubble_page_streamer.sv | 180 ++++++++++++++++++
 tb/tb_bubble_page_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_page_streamer.sv
// bubble_page_streamer
//   Ping-pong page store between the SPI loader and the bubble outputs. The loader
//   fills the back bank while the front bank is serialised onto bubble_out, one
//   word per timing-generator bit strobe. A page_start with no valid front page is
//   flagged as a sticky underrun.
//
// Ports
//   master_clock          in   sole clock, rising edge
//   master_reset          in   synchronous, active-high reset
//   buffer_write_enable   in   loader write strobe
//   buffer_write_address  in   word index within the page
//   buffer_write_data     in   word, bit i -> channel i
//   load_done             in   pulse: back bank completely written
//   load_request          out  back bank empty and accepting writes
//   page_start            in   pulse: begin streaming the front page
//   bit_strobe            in   pulse: one output bit time
//   bubble_out            out  serial page data, one bit per channel
//   page_active           out  a page is streaming
//   underrun              out  sticky: page_start with no valid front page
//   underrun_count        out  saturating underrun event count (only with
//                              BUBBLE_UNDERRUN_CNT_EN defined)
//
// Build option: define BUBBLE_UNDERRUN_CNT_EN to add the underrun_count port.

module bubble_page_streamer #(
    parameter int   CHANNELS   = 2,
    parameter int   PAGE_BITS  = 1168,
    parameter int   ADDR_WIDTH = 11,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  master_clock,
    input  logic                  master_reset,
    input  logic                  buffer_write_enable,
    input  logic [ADDR_WIDTH-1:0] buffer_write_address,
    input  logic [CHANNELS-1:0]   buffer_write_data,
    input  logic                  load_done,
    output logic                  load_request,
    input  logic                  page_start,
    input  logic                  bit_strobe,
    output logic [CHANNELS-1:0]   bubble_out,
    output logic                  page_active,
    output logic                  underrun
`ifdef BUBBLE_UNDERRUN_CNT_EN
    ,
    output logic [7:0]            underrun_count
`endif
);

    // state   | meaning
    // S_IDLE  | no page streaming, outputs at idle level
    // S_STREAM| serialising front bank, one word per bit_strobe
    // S_DRAIN | last word out, next strobe returns outputs to idle level
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    localparam logic [ADDR_WIDTH:0]   PAGE_LEN  = (ADDR_WIDTH+1)'(PAGE_BITS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(PAGE_BITS - 1);
    localparam logic [CHANNELS-1:0]   IDLE_WORD = {CHANNELS{IDLE_LEVEL}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  front_sel_q, front_sel_d;
    logic                  front_valid_q, front_valid_d;
    logic                  back_full_q, back_full_d;
    logic                  underrun_q, underrun_d;
    logic                  wr_ok;
    logic                  swap;

    logic [CHANNELS-1:0]   bank_q [2][PAGE_BITS];

`ifdef BUBBLE_UNDERRUN_CNT_EN
    logic [7:0]            cnt_q, cnt_d;
    assign underrun_count = cnt_q;
`endif

    // The widened compare keeps addresses at or beyond PAGE_BITS out of the store.
    assign wr_ok = buffer_write_enable && !back_full_q
                   && ({1'b0, buffer_write_address} < PAGE_LEN);

    // Swap is held off for the whole of DRAIN even though the front is already invalid.
    assign swap = !front_valid_q && back_full_q && (state_q == S_IDLE);

    always_ff @(posedge master_clock) begin
        if (wr_ok) begin
            bank_q[~front_sel_q][buffer_write_address] <= buffer_write_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        out_d         = out_q;
        front_sel_d   = front_sel_q;
        front_valid_d = front_valid_q;
        back_full_d   = back_full_q;
        underrun_d    = underrun_q;
`ifdef BUBBLE_UNDERRUN_CNT_EN
        cnt_d         = cnt_q;
`endif

        if (!back_full_q && load_done) begin
            back_full_d = 1'b1;
        end

        if (swap) begin
            front_sel_d   = ~front_sel_q;
            front_valid_d = 1'b1;
            back_full_d   = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // A start in the swap cycle sees the pre-swap (invalid) front.
                if (page_start) begin
                    if (front_valid_q) begin
                        state_d = S_STREAM;
                        idx_d   = '0;
                    end else begin
                        underrun_d = 1'b1;
`ifdef BUBBLE_UNDERRUN_CNT_EN
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
`endif
                    end
                end
            end
            S_STREAM: begin
                if (bit_strobe) begin
                    out_d = bank_q[front_sel_q][idx_q];
                    if (idx_q == LAST_IDX) begin
                        front_valid_d = 1'b0;
                        state_d       = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (bit_strobe) begin
                    out_d   = IDLE_WORD;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (master_reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            out_q         <= IDLE_WORD;
            front_sel_q   <= 1'b0;
            front_valid_q <= 1'b0;
            back_full_q   <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef BUBBLE_UNDERRUN_CNT_EN
            cnt_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            out_q         <= out_d;
            front_sel_q   <= front_sel_d;
            front_valid_q <= front_valid_d;
            back_full_q   <= back_full_d;
            underrun_q    <= underrun_d;
`ifdef BUBBLE_UNDERRUN_CNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign load_request = !back_full_q;
    assign bubble_out   = out_q;
    assign page_active  = (state_q != S_IDLE);
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_bubble_page_streamer.sv
// Directed-plus-random bench for bubble_page_streamer. Pages are kept as plain
// arrays; a streamed page must reproduce the array written by the loader.
module tb_bubble_page_streamer;

    localparam int PAGE = 1168;
    typedef logic [1:0] page_t [PAGE];

    logic        master_clock = 1'b0;
    logic        master_reset;
    logic        buffer_write_enable;
    logic [10:0] buffer_write_address;
    logic [1:0]  buffer_write_data;
    logic        load_done;
    logic        load_request;
    logic        page_start;
    logic        bit_strobe;
    logic [1:0]  bubble_out;
    logic        page_active;
    logic        underrun;
`ifdef BUBBLE_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    int total = 0;
    int bad   = 0;

    page_t pa, pb, pc;

    always #5 master_clock = ~master_clock;

    bubble_page_streamer dut (
        .master_clock         (master_clock),
        .master_reset         (master_reset),
        .buffer_write_enable  (buffer_write_enable),
        .buffer_write_address (buffer_write_address),
        .buffer_write_data    (buffer_write_data),
        .load_done            (load_done),
        .load_request         (load_request),
        .page_start           (page_start),
        .bit_strobe           (bit_strobe),
        .bubble_out           (bubble_out),
        .page_active          (page_active),
        .underrun             (underrun)
`ifdef BUBBLE_UNDERRUN_CNT_EN
        ,
        .underrun_count       (underrun_count)
`endif
    );

    task automatic tick();
        @(posedge master_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_inputs();
        buffer_write_enable  = 1'b0;
        buffer_write_address = '0;
        buffer_write_data    = '0;
        load_done            = 1'b0;
        page_start           = 1'b0;
        bit_strobe           = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [1:0] data, input logic done);
        buffer_write_enable  = 1'b1;
        buffer_write_address = 11'(addr);
        buffer_write_data    = data;
        load_done            = done;
        tick();
        clear_inputs();
    endtask

    // Streams a full page (PAGE strobes plus the drain strobe) with random gaps.
    task automatic stream_check(input page_t pg, input string tag);
        logic [1:0] last_v;
        logic [1:0] exp_v;
        int         gap;
        last_v = bubble_out;
        for (int k = 1; k <= PAGE + 1; k++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk({tag, "_hold"}, 8'(bubble_out), 8'(last_v));
            end
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            exp_v = (k <= PAGE) ? pg[k-1] : 2'b11;
            chk({tag, "_data"}, 8'(bubble_out), 8'(exp_v));
            chk({tag, "_active"}, 8'(page_active), 8'(k <= PAGE));
            last_v = exp_v;
        end
    endtask

    initial begin
        int         k;
        int         w;
        int         cyc;
        bit         ld_sent;
        bit         junk_sent;
        bit         s;
        logic [1:0] last_v;
        logic [1:0] exp_v;

        clear_inputs();
        master_reset = 1'b1;
        tick();
        tick();
        master_reset = 1'b0;

        chk("rst_load_request", 8'(load_request), 8'd1);
        chk("rst_bubble_out",   8'(bubble_out),   8'd3);
        chk("rst_page_active",  8'(page_active),  8'd0);
        chk("rst_underrun",     8'(underrun),     8'd0);
`ifdef BUBBLE_UNDERRUN_CNT_EN
        chk("rst_count", underrun_count, 8'd0);
`endif

        // Start with nothing loaded: underrun, no streaming, strobes have no effect.
        page_start = 1'b1;
        tick();
        page_start = 1'b0;
        chk("ur_flag",   8'(underrun),    8'd1);
        chk("ur_active", 8'(page_active), 8'd0);
        chk("ur_out",    8'(bubble_out),  8'd3);
        for (int i = 0; i < 2; i++) begin
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            chk("ur_strobe_out", 8'(bubble_out), 8'd3);
        end
`ifdef BUBBLE_UNDERRUN_CNT_EN
        chk("ur_count1", underrun_count, 8'd1);
`endif

        // Page A: word i = i[1:0]; out-of-range write dropped; last write carries load_done.
        write_word(1200, 2'b01, 1'b0);
        for (int i = 0; i < PAGE; i++) begin
            pa[i] = 2'(i);
            write_word(i, pa[i], i == PAGE - 1);
        end
        chk("a_ld_req_low", 8'(load_request), 8'd0);
        write_word(0, 2'b11, 1'b0);
        chk("a_ld_req_high", 8'(load_request), 8'd1);

        // Stream A while page B is loaded underneath it.
        for (int i = 0; i < PAGE; i++) pb[i] = 2'($urandom_range(0, 3));
        page_start = 1'b1;
        tick();
        page_start = 1'b0;
        chk("a_start_active", 8'(page_active), 8'd1);
        chk("a_start_out",    8'(bubble_out),  8'd3);
        k = 0; w = 0; cyc = 0; ld_sent = 1'b0; junk_sent = 1'b0; last_v = 2'b11;
        while (k < PAGE + 1 && cyc < 20000) begin
            cyc++;
            if (w < PAGE) begin
                buffer_write_enable  = 1'b1;
                buffer_write_address = 11'(w);
                buffer_write_data    = pb[w];
            end else if (!ld_sent) begin
                load_done = 1'b1;
            end else if (!junk_sent) begin
                buffer_write_enable  = 1'b1;
                buffer_write_address = 11'd7;
                buffer_write_data    = ~pb[7];
            end
            page_start = (k == 10);
            s = ($urandom_range(0, 2) == 0);
            bit_strobe = s;
            tick();
            if (w < PAGE) w++;
            else if (!ld_sent) ld_sent = 1'b1;
            else junk_sent = 1'b1;
            clear_inputs();
            if (s) begin
                k++;
                exp_v = (k <= PAGE) ? pa[k-1] : 2'b11;
                chk("a_data",   8'(bubble_out),  8'(exp_v));
                chk("a_active", 8'(page_active), 8'(k <= PAGE));
                last_v = exp_v;
            end else begin
                chk("a_hold", 8'(bubble_out), 8'(last_v));
            end
        end
        chk("a_completed",    8'(k == PAGE + 1), 8'd1);
        chk("a_fill_done",    8'(junk_sent),     8'd1);
        chk("a_no_early_swap", 8'(load_request), 8'd0);
        tick();
        chk("a_swap_after",   8'(load_request),  8'd1);

        // Page B: start and strobe together; the strobe must be ignored.
        page_start = 1'b1;
        bit_strobe = 1'b1;
        tick();
        clear_inputs();
        chk("b_start_active", 8'(page_active), 8'd1);
        chk("b_start_out",    8'(bubble_out),  8'd3);
        stream_check(pb, "b");

        // Nothing loaded again: underrun stays set.
        page_start = 1'b1;
        tick();
        page_start = 1'b0;
        chk("b_ur_active", 8'(page_active), 8'd0);
        chk("b_ur_flag",   8'(underrun),    8'd1);

        // Page C: start lands on the swap edge -> underrun, then a real start.
        for (int i = 0; i < PAGE; i++) begin
            pc[i] = 2'($urandom_range(0, 3));
            write_word(i, pc[i], i == PAGE - 1);
        end
        page_start = 1'b1;
        tick();
        page_start = 1'b0;
        chk("c_swap_start_active", 8'(page_active),  8'd0);
        chk("c_swap_done",         8'(load_request), 8'd1);
        page_start = 1'b1;
        tick();
        page_start = 1'b0;
        chk("c_start_active", 8'(page_active), 8'd1);
        for (int i = 0; i < 100; i++) begin
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            chk("c_data", 8'(bubble_out), 8'(pc[i]));
        end

        // Reset mid-page aborts everything.
        master_reset = 1'b1;
        tick();
        master_reset = 1'b0;
        chk("mid_rst_active",   8'(page_active),  8'd0);
        chk("mid_rst_out",      8'(bubble_out),   8'd3);
        chk("mid_rst_underrun", 8'(underrun),     8'd0);
        chk("mid_rst_ld_req",   8'(load_request), 8'd1);
        bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
        chk("mid_rst_strobe_out", 8'(bubble_out), 8'd3);

`ifdef BUBBLE_UNDERRUN_CNT_EN
        chk("mid_rst_count", underrun_count, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            page_start = 1'b1;
            tick();
            page_start = 1'b0;
            if (i == 5)   chk("count_5",   underrun_count, 8'd5);
            if (i == 255) chk("count_255", underrun_count, 8'd255);
        end
        chk("count_sat", underrun_count, 8'd255);
        master_reset = 1'b1;
        tick();
        master_reset = 1'b0;
        chk("count_rst", underrun_count, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
